sum_collector: RTL

Drain end of the vector-multiplier datapath: consumes the scalar `final_sum` produced by `adder_tree` once per launched row and packs MATRIX_SIZE consecutive results into one flattened output vector. Tracks adder-tree pipeline latency with a valid shift line, double-buffers (fill + output registers) and presents the vector on a valid/ready handshake. Issues `in_ready` back to the row feeder so no in-flight sum is ever dropped.

---
 rtl/vec_mul_pkg.sv | 28 ++
 rtl/sum_collector_valid_pipe.sv | 36 +++
 rtl/sum_collector.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiplier datapath: default widths,
// collector state encoding and a width helper for index/counter registers.
package vec_mul_pkg;

  localparam int DEF_PARTIAL_SUM_BW = 20;
  localparam int DEF_MATRIX_SIZE    = 8;
  localparam int DEF_TREE_LATENCY   = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } col_state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sum_collector_valid_pipe.sv
// valid_pipe: shift line that tracks launched rows through the adder tree;
// exposes the tail (sum valid this cycle) and the number of rows in flight.
module valid_pipe #(
  parameter int DEPTH = 1,
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i,
  output logic             tail_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign tail_o = line_q[DEPTH-1];

  always_comb begin
    count_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_o = count_o + CNT_W'(line_q[i]);
    end
  end

endmodule

// File: rtl/sum_collector.sv
// sum_collector: packs MATRIX_SIZE adder-tree results into one output vector
// with fill/output double buffering. Define SUM_COLLECTOR_SAT_EN to saturate on narrowing.
module sum_collector
  import vec_mul_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int OUT_BW         = DEF_PARTIAL_SUM_BW,
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int TREE_LATENCY   = DEF_TREE_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [PARTIAL_SUM_BW-1:0] final_sum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_BW*MATRIX_SIZE-1:0]    out_vec_flat
);

  localparam int IDX_W = idx_w(MATRIX_SIZE);
  localparam int CNT_W = idx_w(TREE_LATENCY + 1);
  localparam int OCC_W = idx_w(2*MATRIX_SIZE + TREE_LATENCY + 1) + 1;
  localparam logic [OCC_W-1:0] VEC_OCC   = OCC_W'(MATRIX_SIZE);
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(2*MATRIX_SIZE);

`ifdef SUM_COLLECTOR_SAT_EN
  localparam logic signed [PARTIAL_SUM_BW-1:0] SAT_MAX =
    (PARTIAL_SUM_BW'(1) << (OUT_BW-1)) - PARTIAL_SUM_BW'(1);
  localparam logic signed [PARTIAL_SUM_BW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  function automatic logic [OUT_BW-1:0] conv(input logic signed [PARTIAL_SUM_BW-1:0] s);
`ifdef SUM_COLLECTOR_SAT_EN
    if (s > SAT_MAX) return SAT_MAX[OUT_BW-1:0];
    if (s < SAT_MIN) return SAT_MIN[OUT_BW-1:0];
`endif
    return s[OUT_BW-1:0];
  endfunction

  col_state_e                     state_q;
  logic                           out_valid_q;
  logic [OUT_BW*MATRIX_SIZE-1:0]  out_vec_q;
  logic [OUT_BW-1:0]              fill_q [MATRIX_SIZE];
  logic [OUT_BW-1:0]              fill_d [MATRIX_SIZE];
  logic [IDX_W-1:0]               fill_idx_q;
  logic [OUT_BW*MATRIX_SIZE-1:0]  fill_flat;
  logic [CNT_W-1:0]               in_flight;
  logic [OCC_W-1:0]               occupancy;
  logic                           accept;
  logic                           cap;
  logic                           fill_done;
  logic                           handshake;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;
  assign fill_done = cap && (fill_idx_q == IDX_W'(MATRIX_SIZE-1));

  valid_pipe #(
    .DEPTH (TREE_LATENCY),
    .CNT_W (CNT_W)
  ) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_i    (accept),
    .tail_o  (cap),
    .count_o (in_flight)
  );

  // Credits span both buffers, so the next vector may start filling while the
  // current one drains; a launch is refused only when every slot is spoken for.
  assign occupancy = (out_valid_q ? VEC_OCC : '0)
                   + ((state_q == STALL) ? VEC_OCC : '0)
                   + OCC_W'(fill_idx_q)
                   + OCC_W'(in_flight);
  assign in_ready  = (occupancy < OCC_LIMIT);

  always_comb begin
    fill_d = fill_q;
    if (cap) fill_d[fill_idx_q] = conv(final_sum);
  end

  always_comb begin
    fill_flat = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      fill_flat[i*OUT_BW +: OUT_BW] = fill_d[i];
    end
  end

  // The completing sum is merged on its way into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      fill_idx_q  <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++) fill_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      if (cap) fill_idx_q <= fill_idx_q + 1'b1;
      case (state_q)
        EMPTY: begin
          if (fill_done) begin
            out_vec_q   <= fill_flat;
            out_valid_q <= 1'b1;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (fill_done && handshake) begin
            out_vec_q <= fill_flat;
          end else if (fill_done) begin
            state_q <= STALL;
          end else if (handshake) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        STALL: begin
          if (handshake) begin
            out_vec_q <= fill_flat;
            state_q   <= FULL;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_vec_flat = out_vec_q;

endmodule
